// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Fixed 32-bit widths here are the package defaults; the RTL itself is parametrised.
package ifu_pkg;

    localparam int ILEN       = 32;
    localparam int WIDTH      = 32;
    localparam int INST_BYTES = 4;

    typedef struct packed {
        logic [ILEN-1:0]  inst;
        logic [WIDTH-1:0] pc;
        logic             filled;
    } ifu_entry_t;

    typedef enum logic {
        RSP_FILL,
        RSP_DROP
    } ifu_rsp_t;

endpackage

// File: rtl/ifu_fetch_queue_inst_buf.sv
// DEPTH-slot circular buffer of {inst, pc}. Slots are allocated at request time
// and filled in order by responses; pops are taken from the head.
module ifu_inst_buf #(
    parameter int WIDTH = 32,
    parameter int ILEN  = 32,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc,
    input  logic [WIDTH-1:0]      alloc_pc,
    input  logic                  fill,
    input  logic [ILEN-1:0]       fill_inst,
    input  logic                  pop,
    input  logic                  flush,
    output logic                  head_valid,
    output logic [ILEN+WIDTH-1:0] head_data,
    output logic [CW-1:0]         count,
    output logic [CW-1:0]         pending
);
    import ifu_pkg::*;

    logic [ILEN-1:0]  inst_q [DEPTH];
    logic [WIDTH-1:0] pc_q   [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic [PW-1:0]    head_q, tail_q, fill_q;
    logic [CW-1:0]    count_q, pending_q;

    // pending_q counts allocated slots still waiting for their response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            fill_q    <= '0;
            count_q   <= '0;
            pending_q <= '0;
        end else if (flush) begin
            head_q    <= '0;
            tail_q    <= '0;
            fill_q    <= '0;
            count_q   <= '0;
            pending_q <= '0;
        end else begin
            if (alloc) tail_q <= tail_q + PW'(1);
            if (fill)  fill_q <= fill_q + PW'(1);
            if (pop)   head_q <= head_q + PW'(1);
            count_q   <= count_q + CW'(alloc) - CW'(pop);
            pending_q <= pending_q + CW'(alloc) - CW'(fill);
        end
    end

    // alloc, fill and pop always address three distinct slots, so their order is irrelevant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filled_q <= '0;
        end else if (flush) begin
            filled_q <= '0;
        end else begin
            if (alloc) filled_q[tail_q] <= 1'b0;
            if (fill)  filled_q[fill_q] <= 1'b1;
            if (pop)   filled_q[head_q] <= 1'b0;
        end
    end

    // NOTE: the payload storage is reset too, so ifu_data reads 0 rather than X after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (!flush) begin
            if (alloc) pc_q[tail_q]   <= alloc_pc;
            if (fill)  inst_q[fill_q] <= fill_inst;
        end
    end

    assign head_valid = (count_q != '0) && filled_q[head_q];
    assign head_data  = {inst_q[head_q], pc_q[head_q]};
    assign count      = count_q;
    assign pending    = pending_q;

endmodule

// File: rtl/ifu_fetch_queue.sv
// Pipelined instruction fetch: issues in-order memory requests against buffer
// credit, routes responses into the buffer or drops stale ones after a redirect.
module ifu_fetch_queue #(
    parameter int               WIDTH    = 32,
    parameter int               ILEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  redirect_valid,
    input  logic [WIDTH-1:0]      redirect_pc,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [WIDTH-1:0]      mem_req_addr,
    input  logic                  mem_rsp_valid,
    input  logic [ILEN-1:0]       mem_rsp_data,
    output logic                  ifu_valid,
    output logic [ILEN+WIDTH-1:0] ifu_data,
    input  logic                  idu_ready
);
    import ifu_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] fetch_pc;
    logic [CW-1:0]    drop_cnt, count, pending, outstanding;
    logic             credit_ok, req_fire, rsp_take, fill, pop, head_valid;
    ifu_rsp_t         rsp_route;

    assign outstanding = drop_cnt + pending;
    assign credit_ok   = ({1'b0, count} + {1'b0, drop_cnt}) < (CW + 1)'(DEPTH);

    // NOTE: the request is combinational, so it is gated by rst to read 0 while reset is held.
    assign mem_req_valid = rst && start && !redirect_valid && credit_ok;
    assign mem_req_addr  = fetch_pc;
    assign req_fire      = mem_req_valid && mem_req_ready;

    assign rsp_route = (drop_cnt != '0) ? RSP_DROP : RSP_FILL;
    assign rsp_take  = mem_rsp_valid && (outstanding != '0);
    assign fill      = rsp_take && (rsp_route == RSP_FILL) && !redirect_valid;

    assign ifu_valid = head_valid;
    assign pop       = head_valid && idu_ready && !redirect_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[WIDTH-1:2], 2'b00};
        end else if (req_fire) begin
            fetch_pc <= fetch_pc + WIDTH'(INST_BYTES);
        end
    end

    // On redirect every response still owed becomes a drop, minus one arriving right now.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            drop_cnt <= outstanding - CW'(rsp_take);
        end else if (rsp_take && (rsp_route == RSP_DROP)) begin
            drop_cnt <= drop_cnt - CW'(1);
        end
    end

    ifu_inst_buf #(
        .WIDTH (WIDTH),
        .ILEN  (ILEN),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .alloc      (req_fire),
        .alloc_pc   (fetch_pc),
        .fill       (fill),
        .fill_inst  (mem_rsp_data),
        .pop        (pop),
        .flush      (redirect_valid),
        .head_valid (head_valid),
        .head_data  (ifu_data),
        .count      (count),
        .pending    (pending)
    );

    rsp_without_req: assert property (@(posedge clk) disable iff (!rst)
        !(mem_rsp_valid && (outstanding == '0)))
        else $error("ifu_fetch_queue: memory response with no request outstanding");

endmodule

// File: doc/ifu_fetch_queue.md
Name: ifu_fetch_queue

Overview:
- Parametrised successor to the single-entry instruction fetch stage.
- Issues in-order fetch requests to instruction memory over a valid/ready request channel and accepts in-order responses.
- Buffers up to DEPTH instructions, each with its PC, and presents them to the IDU over a valid/ready handshake.
- Supports pipelined fetch with multiple requests outstanding, redirect/flush with a new PC, and discard of stale in-flight responses.

Parameters:
- WIDTH, 32, PC width in bits.
- ILEN, 32, instruction width in bits.
- DEPTH, 4, number of buffer slots; power of 2, at least 2.
- RESET_PC, 32'h8000_0000, fetch PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  fetch enable; no new requests are issued while low.
- redirect_valid  in  1  flush the buffer and restart fetch at redirect_pc.
- redirect_pc  in  WIDTH  new fetch PC; bits [1:0] are ignored and forced to 0.
- mem_req_valid  out  1  fetch request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  WIDTH  fetch address.
- mem_rsp_valid  in  1  response valid; always accepted, no ready signal.
- mem_rsp_data  in  ILEN  fetched instruction.
- ifu_valid  out  1  head entry available to the IDU.
- ifu_data  out  ILEN+WIDTH  {inst, pc} of the head entry.
- idu_ready  in  1  IDU consumes the head entry.

Behaviour:
- Reset (rst low, asynchronous) clears all state:
  - fetch_pc = RESET_PC; head, tail and count = 0; all filled bits = 0; drop_cnt = 0.
  - Outputs: mem_req_valid = 0, ifu_valid = 0, ifu_data = 0, mem_req_addr = RESET_PC.
- Reset mid-operation discards all in-flight requests; the memory side is reset together with this block.
- Slot allocation at request time:
  - Request handshake = mem_req_valid && mem_req_ready.
  - On handshake, the tail slot takes pc = fetch_pc with filled = 0; tail++ (wraps mod DEPTH); count++.
  - fetch_pc advances by 4, wrapping mod 2^WIDTH.
- mem_req_valid = start && !redirect_valid && (count + drop_cnt < DEPTH). mem_req_addr = fetch_pc.
- Once asserted, mem_req_valid and mem_req_addr stay stable until accepted. Only redirect_valid or start falling may withdraw the request.
- Responses arrive strictly in request order:
  - If drop_cnt != 0, the response is discarded and drop_cnt decrements.
  - Otherwise the response fills the oldest unfilled slot (fill pointer) and sets its filled bit.
- A response with no request outstanding is a protocol error. It is ignored and flagged by a simulation assertion.
- IDU output:
  - ifu_valid = (count != 0) && filled[head]. ifu_data is driven from the head slot.
  - On ifu_valid && idu_ready: head++ (wraps), count--, filled[head] cleared.
  - ifu_valid and ifu_data hold stable while ifu_valid && !idu_ready.
- Latency:
  - A request accepted at cycle t with its response at cycle t+k gives ifu_valid at cycle t+k+1 (buffer empty ahead of it).
  - No response-to-output bypass.
- Sustained throughput is 1 instruction/cycle when memory and IDU are always ready and k < DEPTH.
- Redirect (redirect_valid high at a posedge):
  - All slots are invalidated: head = tail = fill = count = 0, filled bits cleared.
  - drop_cnt <= drop_cnt + (allocated-unfilled slots) − (1 if a response was discarded this cycle). A response arriving that cycle that would have filled a slot is discarded and not counted in the unfilled total.
  - fetch_pc <= {redirect_pc[WIDTH-1:2], 2'b00}.
  - No request is issued and no pop takes effect in the redirect cycle. The IDU must ignore ifu_valid in that cycle.
  - New requests may start the next cycle while drop_cnt is still non-zero.
- Full: count + drop_cnt == DEPTH blocks requests. A simultaneous pop frees credit only from the next cycle; no same-cycle bypass.
- Simultaneous request, response and pop in one cycle are all legal and update independently. count net change is request − pop.
- Counter widths: count, drop_cnt and outstanding use $clog2(DEPTH+1) bits; pointers use $clog2(DEPTH) bits.

Decomposition:
- Package ifu_pkg:
  - ILEN.
  - Constant INST_BYTES = 4.
  - Typedef ifu_entry_t {logic [ILEN-1:0] inst; logic [WIDTH-1:0] pc; logic filled;}, with WIDTH as the package default of 32.
  - Enum ifu_rsp_t {RSP_FILL, RSP_DROP} for the response-routing decision.
- Sub-module ifu_inst_buf: the DEPTH-slot circular buffer with alloc/fill/pop/flush ports and head/tail/fill pointers.
- The top level keeps fetch_pc, credit logic, drop_cnt and redirect sequencing.

Test Plan:
- Reset release, start=1, memory ready always with 1-cycle response, IDU ready → requests to 0x8000_0000, 0x8000_0004, … one per cycle; ifu_data = {inst, pc} streams with matching PCs, one per cycle.
- IDU not ready, memory always ready, DEPTH=4 → exactly 4 requests issued, then mem_req_valid=0; ifu_valid held with a stable head {inst, 0x8000_0000}; one pop lets exactly one new request through the next cycle.
- 3-cycle memory latency, 3 requests outstanding, redirect_pc=0x8000_0102 → the 3 old responses are dropped; the next request address is 0x8000_0100; the first IDU output has pc 0x8000_0100.
- Redirect in the same cycle as a response, a pop and a requestable slot → no request or pop that cycle; drop_cnt is correct; no stale instruction ever reaches the IDU.
- start=0 mid-stream with 2 outstanding → no new requests; both responses are delivered; ifu_valid drops after the IDU drains them.
- rst asserted low mid-stream → all outputs return to reset values asynchronously; after release, fetch restarts at 0x8000_0000.
